// File: rtl/debounce_teclado_pkg.sv
// rtl/debounce_teclado_pkg.sv - shared types, widths and helpers for the keypad debouncer
package debounce_teclado_pkg;

  localparam int CNT_W    = 16;
  localparam int N_TECLAS = 10;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    FILTRANDO   = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTANDO    = 2'd3
  } estado_t;

  function automatic logic e_one_hot(input logic [N_TECLAS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop synchronizer for the raw keypad lines
module sincronizador_2ff #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce_teclado.sv
// rtl/debounce_teclado.sv - keypad debouncer/encoder; DEBOUNCE_TECLADO_REPETICAO_EN enables auto-repeat
module debounce_teclado
  import debounce_teclado_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS  = 4,
  parameter int REPETICAO_CICLOS = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N_TECLAS-1:0] teclas_raw,
  output logic [N_TECLAS-1:0] codificador,
  output logic                tecla_valida,
  output logic                erro_multitecla,
  output logic                ocupado
);

  if (DEBOUNCE_CICLOS < 2 || DEBOUNCE_CICLOS > 65535 ||
      REPETICAO_CICLOS < 2 || REPETICAO_CICLOS > 65535) begin : g_param_invalido
    $error("debounce_teclado: parameter out of range");
  end

  localparam logic [CNT_W-1:0] DEB_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);
`ifdef DEBOUNCE_TECLADO_REPETICAO_EN
  localparam logic [CNT_W-1:0] REP_FIM = CNT_W'(REPETICAO_CICLOS - 1);
`endif

  logic [N_TECLAS-1:0] s2;
  estado_t             estado_q, estado_d;
  logic [N_TECLAS-1:0] amostra_q, amostra_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_TECLAS-1:0] codificador_q, codificador_d;
  logic                tecla_valida_q, tecla_valida_d;
  logic                erro_q, erro_d;

  sincronizador_2ff #(.W(N_TECLAS)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (teclas_raw),
    .q       (s2)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q       <= OCIOSO;
      amostra_q      <= '0;
      cnt_q          <= '0;
      codificador_q  <= '0;
      tecla_valida_q <= 1'b0;
      erro_q         <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      amostra_q      <= amostra_d;
      cnt_q          <= cnt_d;
      codificador_q  <= codificador_d;
      tecla_valida_q <= tecla_valida_d;
      erro_q         <= erro_d;
    end
  end

  always_comb begin
    estado_d       = estado_q;
    amostra_d      = amostra_q;
    cnt_d          = cnt_q;
    codificador_d  = '0;
    tecla_valida_d = 1'b0;
    erro_d         = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (s2 != '0) begin
          amostra_d = s2;
          cnt_d     = '0;
          estado_d  = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (s2 == '0) begin
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else if (s2 != amostra_q) begin
          amostra_d = s2;
          cnt_d     = '0;
        end else if (cnt_q >= DEB_FIM) begin
          // Stable long enough: one accept decision, then wait for release.
          if (e_one_hot(amostra_q)) begin
            codificador_d  = amostra_q;
            tecla_valida_d = 1'b1;
          end else begin
            erro_d = 1'b1;
          end
          cnt_d    = '0;
          estado_d = PRESSIONADO;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PRESSIONADO: begin
        if (s2 == '0) begin
          cnt_d    = '0;
          estado_d = SOLTANDO;
        end else begin
`ifdef DEBOUNCE_TECLADO_REPETICAO_EN
          if (s2 == amostra_q && e_one_hot(amostra_q)) begin
            if (cnt_q >= REP_FIM) begin
              codificador_d  = amostra_q;
              tecla_valida_d = 1'b1;
              cnt_d          = '0;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end else begin
            cnt_d = '0;
          end
`endif
        end
      end
      SOLTANDO: begin
        // A bounce during release goes back to held without a new key.
        if (s2 != '0) begin
          cnt_d    = '0;
          estado_d = PRESSIONADO;
        end else if (cnt_q >= DEB_FIM) begin
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign codificador     = codificador_q;
  assign tecla_valida    = tecla_valida_q;
  assign erro_multitecla = erro_q;
  assign ocupado         = (estado_q != OCIOSO);

endmodule

// File: tb/tb_debounce_teclado.sv
// tb/tb_debounce_teclado.sv - scoreboard bench for debounce_teclado (DEBOUNCE_CICLOS=4, REPETICAO_CICLOS=8)
module tb_debounce_teclado;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [9:0] teclas_raw;
  logic [9:0] codificador;
  logic       tecla_valida;
  logic       erro_multitecla;
  logic       ocupado;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         edge_n;
    logic [9:0] cod;
    logic       err;
  } ev_t;

  ev_t sb[$];

  debounce_teclado #(.DEBOUNCE_CICLOS(4), .REPETICAO_CICLOS(8)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .teclas_raw      (teclas_raw),
    .codificador     (codificador),
    .tecla_valida    (tecla_valida),
    .erro_multitecla (erro_multitecla),
    .ocupado         (ocupado)
  );

  always #5 clock = ~clock;

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Expected pulse 'dly' rising edges after the next one (edge 1 samples the stimulus).
  task automatic push_ev(input int dly, input logic [9:0] cod, input logic err);
    ev_t e;
    e.edge_n = cyc + dly;
    e.cod    = cod;
    e.err    = err;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    ev_t        e;
    logic [9:0] exp_cod;
    logic       exp_err;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      exp_cod = '0;
      exp_err = 1'b0;
      if (sb.size() > 0 && sb[0].edge_n == cyc) begin
        e       = sb.pop_front();
        exp_cod = e.cod;
        exp_err = e.err;
      end
      chk10("codificador", codificador, exp_cod);
      chk1("tecla_valida", tecla_valida, exp_cod != '0);
      chk1("erro_multitecla", erro_multitecla, exp_err);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    teclas_raw = '0;
    #1;
    chk10("reset_codificador", codificador, 10'h000);
    chk1("reset_ocupado", ocupado, 1'b0);
    tick(3);
    reset_n = 1'b1;
    tick(3);

    // single clean press
    teclas_raw = 10'h008;
    push_ev(7, 10'h008, 1'b0);
    tick(10);
    chk1("ocupado_held", ocupado, 1'b1);
    tick(10);
    teclas_raw = '0;
    tick(12);
    chk1("ocupado_after_release", ocupado, 1'b0);

    // bouncing key never settles
    for (int k = 0; k < 5; k++) begin
      teclas_raw = 10'h004;
      tick(2);
      teclas_raw = '0;
      tick(2);
    end
    tick(6);
    chk1("ocupado_after_bounce", ocupado, 1'b0);

    // two keys at once
    teclas_raw = 10'h011;
    push_ev(7, 10'h000, 1'b1);
    tick(10);
    teclas_raw = '0;
    tick(12);
    chk1("ocupado_after_multi", ocupado, 1'b0);

    // short release bounce gives no second key; full release does
    teclas_raw = 10'h002;
    push_ev(7, 10'h002, 1'b0);
    tick(10);
    teclas_raw = '0;
    tick(2);
    teclas_raw = 10'h002;
    tick(6);
    chk1("ocupado_rebounce", ocupado, 1'b1);
    teclas_raw = '0;
    tick(8);
    chk1("ocupado_full_release", ocupado, 1'b0);
    teclas_raw = 10'h002;
    push_ev(7, 10'h002, 1'b0);
    tick(10);
    teclas_raw = '0;
    tick(12);

    // reset mid-filter with key held
    teclas_raw = 10'h002;
    tick(5);
    chk1("ocupado_filtering", ocupado, 1'b1);
    reset_n = 1'b0;
    #1;
    chk10("midreset_codificador", codificador, 10'h000);
    chk1("midreset_valida", tecla_valida, 1'b0);
    chk1("midreset_ocupado", ocupado, 1'b0);
    tick(3);
    chk1("inreset_ocupado", ocupado, 1'b0);
    reset_n = 1'b1;
    push_ev(7, 10'h002, 1'b0);
    tick(10);
    teclas_raw = '0;
    tick(12);

    // long hold
    teclas_raw = 10'h001;
`ifdef DEBOUNCE_TECLADO_REPETICAO_EN
    for (int k = 0; k < 5; k++) push_ev(7 + 8 * k, 10'h001, 1'b0);
`else
    push_ev(7, 10'h001, 1'b0);
`endif
    tick(40);
    teclas_raw = '0;
    tick(12);
    chk1("ocupado_end", ocupado, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
